orb_axis_tx: RTL and testbench

- AXI4-Stream transmitter on the output side of the ORB matcher.
- Takes the matcher's free-running pixel stream (valid-only, no backpressure) and re-frames it for the DMA S2MM channel: TLAST at end of each line, TUSER on the first pixel of each frame.
- A small FIFO absorbs S2MM backpressure; overflow is flagged rather than stalling the matcher.
- Complements the receive-side wrapper, which consumes the MM2S stream and feeds the matcher.

---
 rtl/orb_axis_tx.sv | 148 ++++++++++++++
 tb/tb_orb_axis_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_axis_tx.sv
// ORB matcher output framer: tags pixels with frame geometry and
// buffers them in a FWFT FIFO toward the S2MM AXI4-Stream channel.
module orb_axis_tx #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int H_ACTIVE           = 720,
    parameter int V_ACTIVE           = 480,
    parameter int FIFO_AW            = 5
) (
    input  logic                            axi_Mclk,
    input  logic                            axi_reset_n,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   pix_data,
    input  logic                            pix_valid,
    input  logic                            pix_sof,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_data,
    output logic                            m_axis_valid,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_keep,
    output logic                            m_axis_last,
    output logic                            m_axis_user,
    input  logic                            m_axis_ready,
    output logic                            frame_done,
    output logic                            overflow,
    output logic [FIFO_AW:0]                fifo_level
);

    localparam int DW    = C_AXIS_TDATA_WIDTH;
    localparam int CW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0]      COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(V_ACTIVE - 1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } ent_t;

    logic [CW-1:0]      col_q;
    logic [CW-1:0]      col_d;
    logic [RW-1:0]      row_q;
    logic [RW-1:0]      row_d;
    logic [CW-1:0]      eff_col;
    logic [RW-1:0]      eff_row;
    ent_t               wr_ent;
    ent_t               head;
    ent_t               mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic               drop;
    logic               ovf_q;
    logic               fdone_q;

    // Tag the incoming pixel with its position and compute the next position.
    always_comb begin
        eff_col = pix_sof ? '0 : col_q;
        eff_row = pix_sof ? '0 : row_q;
        wr_ent.data = pix_data;
        wr_ent.sof  = (eff_col == '0) && (eff_row == '0);
        wr_ent.eol  = (eff_col == COL_LAST);
        wr_ent.eof  = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
        end
    end

    // Position counters advance on every valid pixel, dropped or not.
    always_ff @(posedge axi_Mclk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign rd_en = !empty && m_axis_ready;
    assign wr_en = pix_valid && (!full || rd_en);
    assign drop  = pix_valid && full && !rd_en;
    assign head  = mem[rd_ptr];

    // Storage array; contents are only observed through a valid head.
    always_ff @(posedge axi_Mclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_ent;
        end
    end

    // Pointers and occupancy move together on the same edge.
    always_ff @(posedge axi_Mclk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (wr_en && !rd_en): level_q <= level_q + 1'b1;
                (rd_en && !wr_en): level_q <= level_q - 1'b1;
                default:           level_q <= level_q;
            endcase
        end
    end

    // Sticky drop flag and end-of-frame pulse.
    always_ff @(posedge axi_Mclk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            ovf_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_q | drop;
            fdone_q <= rd_en && head.eof;
        end
    end

    assign m_axis_valid = !empty;
    assign m_axis_data  = empty ? '0 : head.data;
    assign m_axis_last  = !empty && head.eol;
    assign m_axis_user  = !empty && head.sof;
    assign m_axis_keep  = empty ? '0 : '1;
    assign frame_done   = fdone_q;
    assign overflow     = ovf_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_orb_axis_tx.sv
// Scoreboard bench for orb_axis_tx: a negedge monitor predicts FIFO
// contents, tags and flags; scenario tasks add targeted checks.
module tb_orb_axis_tx;

    localparam int DW    = 32;
    localparam int H     = 8;
    localparam int V     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic [3:0]    m_axis_keep;
    logic          m_axis_last;
    logic          m_axis_user;
    logic          m_axis_ready = 1'b0;
    logic          frame_done;
    logic          overflow;
    logic [AW:0]   fifo_level;

    orb_axis_tx #(
        .C_AXIS_TDATA_WIDTH(DW),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .FIFO_AW(AW)
    ) dut (
        .axi_Mclk(clk),
        .axi_reset_n(rst_n),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_sof(pix_sof),
        .m_axis_data(m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_keep(m_axis_keep),
        .m_axis_last(m_axis_last),
        .m_axis_user(m_axis_user),
        .m_axis_ready(m_axis_ready),
        .frame_done(frame_done),
        .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          user;
        logic          last;
        logic          eof;
    } exp_t;

    exp_t          q[$];
    logic [1:0]    blog[$];
    int            checks = 0;
    int            errors = 0;
    int            mcol = 0;
    int            mrow = 0;
    bit            exp_ovf = 1'b0;
    bit            exp_fd = 1'b0;
    int            drops = 0;
    int            fd_cnt = 0;
    int            max_lvl = 0;
    int            stall_cnt = 0;
    bit            stalled = 1'b0;
    logic [DW+1:0] prev_out = '0;
    logic [DW-1:0] dcnt = 32'hA000_0000;

    // Monitor: compare outputs to the model, then advance the model
    // for the edge that follows.
    always @(negedge clk) begin
        if (rst_n) begin
            bit   rd;
            bit   full;
            exp_t e;
            exp_t h;
            int   ec;
            int   er;
            rd   = m_axis_valid && m_axis_ready;
            full = (q.size() == DEPTH);
            checks++;
            if (fifo_level !== 4'(q.size())) begin
                errors++;
                $display("FAIL level: got %0d expected %0d", fifo_level, q.size());
            end
            checks++;
            if (m_axis_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL valid: got %b expected %b", m_axis_valid, q.size() != 0);
            end
            checks++;
            if (q.size() != 0) begin
                if ({m_axis_data, m_axis_user, m_axis_last, m_axis_keep} !==
                    {q[0].d, q[0].user, q[0].last, 4'hF}) begin
                    errors++;
                    $display("FAIL head: got d=%h u=%b l=%b k=%h expected d=%h u=%b l=%b k=f",
                             m_axis_data, m_axis_user, m_axis_last, m_axis_keep,
                             q[0].d, q[0].user, q[0].last);
                end
            end else if (m_axis_keep !== 4'h0) begin
                errors++;
                $display("FAIL keep_idle: got %h expected 0", m_axis_keep);
            end
            if (stalled) begin
                stall_cnt++;
                checks++;
                if ({m_axis_data, m_axis_user, m_axis_last} !== prev_out) begin
                    errors++;
                    $display("FAIL hold: got %h expected %h",
                             {m_axis_data, m_axis_user, m_axis_last}, prev_out);
                end
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL frame_done: got %b expected %b", frame_done, exp_fd);
            end
            if (frame_done === 1'b1) fd_cnt++;
            checks++;
            if (overflow !== exp_ovf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b", overflow, exp_ovf);
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            stalled  = m_axis_valid && !m_axis_ready;
            prev_out = {m_axis_data, m_axis_user, m_axis_last};
            exp_fd   = 1'b0;
            if (rd && q.size() != 0) begin
                h = q.pop_front();
                exp_fd = h.eof;
                blog.push_back({h.user, h.last});
            end
            if (pix_valid) begin
                ec = pix_sof ? 0 : mcol;
                er = pix_sof ? 0 : mrow;
                e.d    = pix_data;
                e.user = (ec == 0) && (er == 0);
                e.last = (ec == H - 1);
                e.eof  = (ec == H - 1) && (er == V - 1);
                if (!full || rd) q.push_back(e);
                else begin
                    drops++;
                    exp_ovf = 1'b1;
                end
                if (ec == H - 1) begin
                    mcol = 0;
                    mrow = (er == V - 1) ? 0 : er + 1;
                end else begin
                    mcol = ec + 1;
                    mrow = er;
                end
            end
        end
    end

    task automatic step(input bit v, input bit s, input bit r);
        @(posedge clk);
        #1;
        pix_valid    = v;
        pix_sof      = s & v;
        m_axis_ready = r;
        if (v) begin
            pix_data = dcnt;
            dcnt     = dcnt + 1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            step(0, 0, 1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d left expected 0", q.size());
        end
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
    endtask

    task automatic clr();
        drops     = 0;
        fd_cnt    = 0;
        max_lvl   = 0;
        stall_cnt = 0;
        blog.delete();
    endtask

    task automatic masks(output logic [63:0] u, output logic [63:0] l);
        u = '0;
        l = '0;
        for (int i = 0; i < blog.size() && i < 64; i++) begin
            u[i] = blog[i][1];
            l[i] = blog[i][0];
        end
    endtask

    task automatic test_reset();
        pix_valid    = 1'b0;
        pix_sof      = 1'b0;
        m_axis_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b expected 0", m_axis_valid);
        end
        checks++;
        if (m_axis_data !== '0) begin
            errors++;
            $display("FAIL rst_data: got %h expected 0", m_axis_data);
        end
        checks++;
        if ({m_axis_keep, m_axis_last, m_axis_user} !== 6'b0) begin
            errors++;
            $display("FAIL rst_klu: got %b expected 0", {m_axis_keep, m_axis_last, m_axis_user});
        end
        checks++;
        if (fifo_level !== '0) begin
            errors++;
            $display("FAIL rst_level: got %0d expected 0", fifo_level);
        end
        checks++;
        if ({overflow, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_flags: got %b expected 00", {overflow, frame_done});
        end
        q.delete();
        mcol    = 0;
        mrow    = 0;
        exp_ovf = 1'b0;
        exp_fd  = 1'b0;
        stalled = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input string tag);
        logic [63:0] u;
        logic [63:0] l;
        clr();
        for (int i = 0; i < 32; i++) step(1, i == 0, 1);
        drain();
        masks(u, l);
        checks++;
        if (blog.size() != 32) begin
            errors++;
            $display("FAIL %s_beats: got %0d expected 32", tag, blog.size());
        end
        checks++;
        if (l !== 64'h0000_0000_8080_8080) begin
            errors++;
            $display("FAIL %s_last: got %h expected 80808080", tag, l);
        end
        checks++;
        if (u !== 64'h1) begin
            errors++;
            $display("FAIL %s_user: got %h expected 1", tag, u);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL %s_fdone: got %0d expected 1", tag, fd_cnt);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf: got %b expected 0", tag, overflow);
        end
    endtask

    task automatic test_basic();
        run_frame("basic");
    endtask

    task automatic test_full_rw();
        clr();
        for (int i = 0; i < 8; i++) step(1, i == 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL fullrw_level: got %0d expected 8", fifo_level);
        end
        checks++;
        if (overflow !== 1'b0 || drops != 0) begin
            errors++;
            $display("FAIL fullrw_ovf: got %b/%0d expected 0/0", overflow, drops);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [63:0] u;
        logic [63:0] l;
        clr();
        for (int i = 0; i < 32; i++) step(1, i == 0, i >= 12);
        for (int i = 0; i < 32; i++) step(1, 0, 1);
        drain();
        masks(u, l);
        checks++;
        if (drops != 4) begin
            errors++;
            $display("FAIL ovf_drops: got %0d expected 4", drops);
        end
        checks++;
        if (max_lvl != 8) begin
            errors++;
            $display("FAIL ovf_maxlvl: got %0d expected 8", max_lvl);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        checks++;
        if (blog.size() != 60) begin
            errors++;
            $display("FAIL ovf_beats: got %0d expected 60", blog.size());
        end
        checks++;
        if (u !== 64'h0000_0000_1000_0001) begin
            errors++;
            $display("FAIL ovf_user: got %h expected 10000001", u);
        end
        checks++;
        if (l !== 64'h0808_0808_0808_0880) begin
            errors++;
            $display("FAIL ovf_last: got %h expected 0808080808080880", l);
        end
    endtask

    task automatic test_sof_midline();
        logic [63:0] u;
        logic [63:0] l;
        clr();
        for (int i = 0; i < 21; i++) step(1, i == 0, 1);
        step(1, 1, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 1);
        drain();
        masks(u, l);
        checks++;
        if (u !== 64'h0000_0000_0020_0001) begin
            errors++;
            $display("FAIL sofmid_user: got %h expected 200001", u);
        end
        checks++;
        if (l !== 64'h0000_0000_1000_8080) begin
            errors++;
            $display("FAIL sofmid_last: got %h expected 10008080", l);
        end
    endtask

    task automatic test_toggle();
        logic [63:0] u;
        logic [63:0] l;
        clr();
        for (int i = 0; i < 96; i++) step(i % 3 == 0, i == 0, i % 2 == 1);
        drain();
        masks(u, l);
        checks++;
        if (blog.size() != 32 || drops != 0) begin
            errors++;
            $display("FAIL toggle_beats: got %0d/%0d expected 32/0", blog.size(), drops);
        end
        checks++;
        if (stall_cnt == 0) begin
            errors++;
            $display("FAIL toggle_stalls: got 0 expected >0");
        end
        checks++;
        if (l !== 64'h0000_0000_8080_8080 || u !== 64'h1 || fd_cnt != 1) begin
            errors++;
            $display("FAIL toggle_tags: got l=%h u=%h fd=%0d expected 80808080/1/1", l, u, fd_cnt);
        end
    endtask

    task automatic test_async_reset();
        clr();
        for (int i = 0; i < 5; i++) step(1, i == 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (fifo_level !== 4'd5) begin
            errors++;
            $display("FAIL arst_prelevel: got %0d expected 5", fifo_level);
        end
        test_reset();
        run_frame("arst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_rw();
        test_overflow();
        test_reset();
        test_sof_midline();
        test_toggle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
